// File: rtl/count_select_seq.sv
// count_select_seq: modulo-MODULUS up/down counter with parallel load, enable
// and one-shot halt, plus a registered one-hot select bus of polarity
// SEL_ACTIVE_LOW. Reports wrap, one-shot completion and clamped loads.
module count_select_seq #(
    parameter int WIDTH          = 7,
    parameter int MODULUS        = 128,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               up_dn,
    input  logic               one_shot,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   count,
    output logic [MODULUS-1:0] select,
    output logic               wrap,
    output logic               done,
    output logic               load_err
);

    // Arithmetic runs one bit wider so MODULUS == 2^WIDTH is representable.
    localparam logic [WIDTH:0]     MOD_W   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]     LAST    = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0]     STEP    = (WIDTH+1)'(1);
    localparam logic               SEL_LOW = (SEL_ACTIVE_LOW != 0);
    localparam logic [MODULUS-1:0] SEL_ONE = {{(MODULUS-1){1'b0}}, 1'b1};
    localparam logic [MODULUS-1:0] SEL_RST = SEL_LOW ? ~SEL_ONE : SEL_ONE;

    logic [WIDTH:0]     cnt_cur;
    logic [WIDTH:0]     cnt_next;
    logic [WIDTH:0]     load_ext;
    logic [MODULUS-1:0] sel_next;
    logic               at_term;
    logic               wrap_next;
    logic               done_next;
    logic               lerr_next;

    // Next-state: load beats enable; done freezes the count until a load.
    always_comb begin
        cnt_cur   = {1'b0, count};
        load_ext  = {1'b0, load_val};
        cnt_next  = cnt_cur;
        wrap_next = 1'b0;
        lerr_next = 1'b0;
        done_next = done;
        // >= on the up side keeps a non-power-of-two range from ever escaping
        at_term   = up_dn ? (cnt_cur >= LAST) : (cnt_cur == '0);
        if (load) begin
            done_next = 1'b0;
            if (load_ext < MOD_W) begin
                cnt_next = load_ext;
            end else begin
                cnt_next  = LAST;
                lerr_next = 1'b1;
            end
        end else if (en && !done) begin
            if (at_term) begin
                if (one_shot) begin
                    done_next = 1'b1;
                end else begin
                    cnt_next  = up_dn ? '0 : LAST;
                    wrap_next = 1'b1;
                end
            end else if (up_dn) begin
                cnt_next = cnt_cur + STEP;
            end else begin
                cnt_next = cnt_cur - STEP;
            end
        end
    end

    // Decode from the next count so select lands on the same edge as count.
    for (genvar i = 0; i < MODULUS; i++) begin : g_sel
        localparam logic [WIDTH:0] IDX = (WIDTH+1)'(i);
        assign sel_next[i] = (cnt_next == IDX) ^ SEL_LOW;
    end

    // State and flag registers; reset drops any pending pulse immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            select   <= SEL_RST;
            wrap     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= cnt_next[WIDTH-1:0];
            select   <= sel_next;
            wrap     <= wrap_next;
            done     <= done_next;
            load_err <= lerr_next;
        end
    end

endmodule

// File: tb/tb_count_select_seq.sv
// Bench for count_select_seq: three instances (128 active-low, 100 active-low,
// 8 active-high) checked against an arithmetic reference model.
module tb_count_select_seq;

    typedef struct {
        int cnt;
        bit done;
        bit wrap;
        bit lerr;
    } mstate_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic a_en = 0, a_up = 0, a_os = 0, a_ld = 0;
    logic [6:0] a_lv = '0;
    logic [6:0] a_cnt;
    logic [127:0] a_sel;
    logic a_wrap, a_done, a_lerr;

    logic b_en = 0, b_up = 0, b_os = 0, b_ld = 0;
    logic [6:0] b_lv = '0;
    logic [6:0] b_cnt;
    logic [99:0] b_sel;
    logic b_wrap, b_done, b_lerr;

    logic c_en = 0, c_up = 0, c_os = 0, c_ld = 0;
    logic [3:0] c_lv = '0;
    logic [3:0] c_cnt;
    logic [7:0] c_sel;
    logic c_wrap, c_done, c_lerr;

    int checks = 0;
    int failures = 0;
    mstate_t ma, mb, mc;

    always #5 clk = ~clk;

    count_select_seq #(.WIDTH(7), .MODULUS(128), .SEL_ACTIVE_LOW(1)) dut_a (
        .clk(clk), .reset(reset), .en(a_en), .up_dn(a_up), .one_shot(a_os),
        .load(a_ld), .load_val(a_lv), .count(a_cnt), .select(a_sel),
        .wrap(a_wrap), .done(a_done), .load_err(a_lerr));

    count_select_seq #(.WIDTH(7), .MODULUS(100), .SEL_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .reset(reset), .en(b_en), .up_dn(b_up), .one_shot(b_os),
        .load(b_ld), .load_val(b_lv), .count(b_cnt), .select(b_sel),
        .wrap(b_wrap), .done(b_done), .load_err(b_lerr));

    count_select_seq #(.WIDTH(4), .MODULUS(8), .SEL_ACTIVE_LOW(0)) dut_c (
        .clk(clk), .reset(reset), .en(c_en), .up_dn(c_up), .one_shot(c_os),
        .load(c_ld), .load_val(c_lv), .count(c_cnt), .select(c_sel),
        .wrap(c_wrap), .done(c_done), .load_err(c_lerr));

    // Reference: a step moves the count by one; leaving 0..m-1 is a wrap
    // (free-run) or completion (one-shot). Loads clamp to m-1.
    function automatic mstate_t model_step(mstate_t s, int m, bit e, bit u,
                                           bit o, bit l, int lv);
        mstate_t r = s;
        int nxt;
        r.wrap = 0;
        r.lerr = 0;
        nxt = u ? s.cnt + 1 : s.cnt - 1;
        if (l) begin
            r.done = 0;
            if (lv < m) r.cnt = lv;
            else begin
                r.cnt = m - 1;
                r.lerr = 1;
            end
        end else if (e && !s.done) begin
            if (nxt < 0 || nxt >= m) begin
                if (o) r.done = 1;
                else begin
                    r.cnt = (nxt + m) % m;
                    r.wrap = 1;
                end
            end else begin
                r.cnt = nxt;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int d);
        logic [127:0] ea;
        logic [99:0]  eb;
        logic [7:0]   ec;
        case (d)
            0: begin
                ea = ~(128'b1 << ma.cnt);
                chk("a_count", a_cnt, ma.cnt);
                chk("a_select", a_sel, ea);
                chk("a_wrap", a_wrap, ma.wrap);
                chk("a_done", a_done, ma.done);
                chk("a_load_err", a_lerr, ma.lerr);
            end
            1: begin
                eb = ~(100'b1 << mb.cnt);
                chk("b_count", b_cnt, mb.cnt);
                chk("b_select", b_sel, eb);
                chk("b_wrap", b_wrap, mb.wrap);
                chk("b_done", b_done, mb.done);
                chk("b_load_err", b_lerr, mb.lerr);
                chk("b_range", b_cnt < 7'd100, 1);
            end
            default: begin
                ec = 8'b1 << mc.cnt;
                chk("c_count", c_cnt, mc.cnt);
                chk("c_select", c_sel, ec);
                chk("c_popcount", $countones(c_sel), 1);
                chk("c_range", c_cnt < 4'd8, 1);
                chk("c_wrap", c_wrap, mc.wrap);
                chk("c_done", c_done, mc.done);
                chk("c_load_err", c_lerr, mc.lerr);
            end
        endcase
    endtask

    // One clocked step on one instance; the other instances sit idle.
    task automatic step(input int d, input bit e, input bit u, input bit o,
                        input bit l, input int lv);
        @(negedge clk);
        case (d)
            0: begin a_en = e; a_up = u; a_os = o; a_ld = l; a_lv = 7'(lv); end
            1: begin b_en = e; b_up = u; b_os = o; b_ld = l; b_lv = 7'(lv); end
            default: begin c_en = e; c_up = u; c_os = o; c_ld = l; c_lv = 4'(lv); end
        endcase
        @(posedge clk);
        #1;
        case (d)
            0: ma = model_step(ma, 128, e, u, o, l, lv);
            1: mb = model_step(mb, 100, e, u, o, l, lv);
            default: mc = model_step(mc, 8, e, u, o, l, lv);
        endcase
        a_en = 0; a_ld = 0; b_en = 0; b_ld = 0; c_en = 0; c_ld = 0;
        check_dut(d);
    endtask

    task automatic model_reset();
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        mc = '{0, 0, 0, 0};
    endtask

    initial begin
        int wraps;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_sel", a_sel, {{127{1'b1}}, 1'b0});
        check_dut(0);
        check_dut(1);
        check_dut(2);
        @(negedge clk);
        reset = 0;

        // Async reset between edges clears the count without a clock edge.
        repeat (5) step(0, 1, 1, 0, 0, 0);
        chk("a_pre_reset", a_cnt, 5);
        @(negedge clk);
        #2;
        reset = 1;
        #1;
        model_reset();
        chk("a_async_cnt", a_cnt, 0);
        chk("a_async_sel", a_sel, {{127{1'b1}}, 1'b0});
        @(negedge clk);
        reset = 0;

        // Free-run sweep through the full 128 range and one wrap.
        wraps = 0;
        for (int i = 0; i < 130; i++) begin
            step(0, 1, 1, 0, 0, 0);
            if (a_wrap === 1'b1) wraps++;
        end
        chk("a_wrap_once", wraps, 1);
        chk("a_after_sweep", a_cnt, 2);

        // Non-power-of-two: down from 0 wraps to 99.
        step(1, 1, 0, 0, 0, 0);
        chk("b_down_wrap_cnt", b_cnt, 99);
        chk("b_down_wrap_pulse", b_wrap, 1);
        step(1, 1, 0, 0, 0, 0);
        chk("b_down_98", b_cnt, 98);
        chk("b_wrap_gone", b_wrap, 0);
        step(1, 0, 0, 0, 1, 120);
        chk("b_clamp_cnt", b_cnt, 99);
        chk("b_clamp_err", b_lerr, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("b_err_gone", b_lerr, 0);

        // One-shot halts at the terminal value.
        step(1, 0, 1, 1, 1, 97);
        step(1, 1, 1, 1, 0, 0);
        chk("b_os_98", b_cnt, 98);
        step(1, 1, 1, 1, 0, 0);
        chk("b_os_99", b_cnt, 99);
        step(1, 1, 1, 1, 0, 0);
        chk("b_os_hold", b_cnt, 99);
        chk("b_os_done", b_done, 1);
        chk("b_os_nowrap", b_wrap, 0);
        repeat (3) step(1, 1, 1, 0, 0, 0);
        chk("b_done_sticky", b_cnt, 99);
        step(1, 0, 1, 1, 1, 5);
        chk("b_reload_cnt", b_cnt, 5);
        chk("b_reload_done", b_done, 0);

        // Load wins over enable, then direction reversal each cycle.
        step(1, 1, 1, 0, 1, 40);
        chk("b_load_prio", b_cnt, 40);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, (i % 2) == 0, 0, 0, 0);
            chk("b_reverse", b_cnt, ((i % 2) == 0) ? 41 : 40);
        end

        // Randomized run on the modulus-100 instance.
        for (int i = 0; i < 300; i++)
            step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 127));

        // Reset during the wrap-pulse cycle kills the pulse at once.
        step(1, 0, 1, 0, 1, 99);
        step(1, 1, 1, 0, 0, 0);
        chk("b_wrap_before_rst", b_wrap, 1);
        #1;
        reset = 1;
        #1;
        model_reset();
        chk("b_rst_wrap", b_wrap, 0);
        chk("b_rst_cnt", b_cnt, 0);
        check_dut(1);
        @(negedge clk);
        reset = 0;

        // Active-high select, modulus 8, random traffic.
        for (int i = 0; i < 10000; i++)
            step(2, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
